// File: rtl/ysyx_22050133_mdu_seq_pkg.sv
// Shared definitions for the M-extension multiply/divide sequencer:
// ALUop codes as decoded by EX, FSM state encoding, iteration counts
// and small helpers used by both the sequencer and its environment.
package ysyx_22050133_mdu_seq_pkg;

    // ALUop codes for the M extension (EX decode).
    localparam logic [4:0] ALUop_MUL    = 5'h10;
    localparam logic [4:0] ALUop_MULH   = 5'h11;
    localparam logic [4:0] ALUop_MULHSU = 5'h12;
    localparam logic [4:0] ALUop_MULHU  = 5'h13;
    localparam logic [4:0] ALUop_DIV    = 5'h14;
    localparam logic [4:0] ALUop_DIVU   = 5'h15;
    localparam logic [4:0] ALUop_REM    = 5'h16;
    localparam logic [4:0] ALUop_REMU   = 5'h17;

    // Sequencer state encoding.
    localparam logic [2:0] ysyx_22050133_MDU_S_IDLE  = 3'd0;
    localparam logic [2:0] ysyx_22050133_MDU_S_PREP  = 3'd1;
    localparam logic [2:0] ysyx_22050133_MDU_S_MLOOP = 3'd2;
    localparam logic [2:0] ysyx_22050133_MDU_S_DLOOP = 3'd3;
    localparam logic [2:0] ysyx_22050133_MDU_S_FIX   = 3'd4;
    localparam logic [2:0] ysyx_22050133_MDU_S_DONE  = 3'd5;

    // Loop lengths for W and full-width operations.
    localparam int ysyx_22050133_MDU_W_ITERS = 32;
    localparam int ysyx_22050133_MDU_D_ITERS = 64;

    // Ops that return the high half of the product.
    function automatic logic mdu_is_mul_hi(input logic [4:0] op);
        return (op == ALUop_MULH) || (op == ALUop_MULHSU) || (op == ALUop_MULHU);
    endfunction

    function automatic logic [63:0] mdu_sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22050133_mdu_iter.sv
// One combinational step of the multi-cycle datapath.
//   is_div_i = 0 : shift-add multiply step. acc_i[63:0] holds the remaining
//                  multiplier bits, acc_i[127:64] the partial product;
//                  opb_i is the multiplicand.
//   is_div_i = 1 : restoring divide step. acc_i[127:64] is the partial
//                  remainder, acc_i[63:0] the dividend bits being shifted
//                  out while quotient bits shift in; opb_i is the divisor.
//   acc_o        : accumulator after the step.
module ysyx_22050133_mdu_iter (
    input  logic         is_div_i,
    input  logic [127:0] acc_i,
    input  logic [63:0]  opb_i,
    output logic [127:0] acc_o
);

    logic [64:0] add_sum;
    logic [64:0] rem_sh;
    logic [63:0] rem_diff;

    always_comb begin
        // Carry out of the add becomes the new top bit after the right shift.
        add_sum  = {1'b0, acc_i[127:64]} + (acc_i[0] ? {1'b0, opb_i} : 65'd0);
        rem_sh   = {acc_i[127:64], acc_i[63]};
        // Only consumed when rem_sh >= divisor, so the 64-bit wrap is exact.
        rem_diff = rem_sh[63:0] - opb_i;
        if (is_div_i) begin
            if (rem_sh >= {1'b0, opb_i}) begin
                acc_o = {rem_diff, acc_i[62:0], 1'b1};
            end else begin
                // Here rem_sh < divisor < 2^64, so bit 64 is zero.
                acc_o = {rem_sh[63:0], acc_i[62:0], 1'b0};
            end
        end else begin
            acc_o = {add_sum, acc_i[63:1]};
        end
    end

endmodule

// File: rtl/ysyx_22050133_mdu_seq.sv
// Multi-cycle multiply/divide sequencer for the RV64IM EX stage.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   op handshake (in_ready only in IDLE)
//   aluop, word           M-extension op code and RV64 W flag
//   src1, src2            rs1/rs2 operands
//   flush                 kill in-flight op, return to IDLE
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   result                final rd value, already W-sign-extended
//   busy                  high whenever not IDLE
//   dbg_state             current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; flush in the same cycle cancels the transfer.
module ysyx_22050133_mdu_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      aluop,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [2:0]      dbg_state
);

    import ysyx_22050133_mdu_seq_pkg::*;

    logic [2:0]   state_q, state_d;
    logic [4:0]   op_q, op_d;
    logic         word_q, word_d;
    logic [63:0]  a_q, a_d, b_q, b_d;
    logic [127:0] acc_q, acc_d;
    logic [5:0]   cnt_q, cnt_d;
    logic         neg_q, neg_d, rneg_q, rneg_d;
    logic [63:0]  result_q, result_d;

    logic         accept, is_div, is_rem, mul_hi, sign_a, sign_b;
    logic [63:0]  opa, opb, mag_a, mag_b, min_val;
    logic         a_neg, b_neg, div_zero, div_ovf;
    logic [127:0] iter_acc, prod, prod_s;
    logic [63:0]  quo_s, rem_s, raw_res, fix_res;

    assign accept = (state_q == ysyx_22050133_MDU_S_IDLE) && in_valid && !flush;

    // Op decode and operand preparation, valid while in PREP.
    always_comb begin
        is_div  = (op_q == ALUop_DIV) || (op_q == ALUop_DIVU) ||
                  (op_q == ALUop_REM) || (op_q == ALUop_REMU);
        is_rem  = (op_q == ALUop_REM) || (op_q == ALUop_REMU);
        mul_hi  = mdu_is_mul_hi(op_q);
        sign_a  = (op_q == ALUop_MULH) || (op_q == ALUop_MULHSU) ||
                  (op_q == ALUop_DIV)  || (op_q == ALUop_REM);
        sign_b  = (op_q == ALUop_MULH) || (op_q == ALUop_DIV) || (op_q == ALUop_REM);
        opa     = word_q ? (sign_a ? mdu_sext32(a_q[31:0]) : {32'd0, a_q[31:0]}) : a_q;
        opb     = word_q ? (sign_b ? mdu_sext32(b_q[31:0]) : {32'd0, b_q[31:0]}) : b_q;
        a_neg   = sign_a && opa[63];
        b_neg   = sign_b && opb[63];
        mag_a   = a_neg ? (64'd0 - opa) : opa;
        mag_b   = b_neg ? (64'd0 - opb) : opb;
        min_val = word_q ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_zero = is_div && (opb == 64'd0);
        div_ovf  = is_div && sign_b && (opb == {64{1'b1}}) && (opa == min_val);
    end

    ysyx_22050133_mdu_iter u_iter (
        .is_div_i (is_div),
        .acc_i    (acc_q),
        .opb_i    (b_q),
        .acc_o    (iter_acc)
    );

    // Final sign fix-up and selection, consumed in FIX.
    always_comb begin
        // A W multiply leaves its product shifted up by 32 in the accumulator.
        prod    = word_q ? {32'd0, acc_q[127:32]} : acc_q;
        prod_s  = neg_q ? (128'd0 - prod) : prod;
        quo_s   = neg_q ? (64'd0 - acc_q[63:0]) : acc_q[63:0];
        rem_s   = rneg_q ? (64'd0 - acc_q[127:64]) : acc_q[127:64];
        if (is_div) begin
            raw_res = is_rem ? rem_s : quo_s;
        end else begin
            raw_res = mul_hi ? prod_s[127:64] : prod_s[63:0];
        end
        fix_res = word_q ? mdu_sext32(raw_res[31:0]) : raw_res;
    end

    // FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ysyx_22050133_MDU_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ysyx_22050133_MDU_S_IDLE;
        end else begin
            case (state_q)
                ysyx_22050133_MDU_S_IDLE:  if (in_valid) state_d = ysyx_22050133_MDU_S_PREP;
                ysyx_22050133_MDU_S_PREP: begin
                    if (div_zero || div_ovf) state_d = ysyx_22050133_MDU_S_FIX;
                    else if (is_div)         state_d = ysyx_22050133_MDU_S_DLOOP;
                    else                     state_d = ysyx_22050133_MDU_S_MLOOP;
                end
                ysyx_22050133_MDU_S_MLOOP,
                ysyx_22050133_MDU_S_DLOOP: if (cnt_q == 6'd0) state_d = ysyx_22050133_MDU_S_FIX;
                ysyx_22050133_MDU_S_FIX:   state_d = ysyx_22050133_MDU_S_DONE;
                ysyx_22050133_MDU_S_DONE:  if (out_ready) state_d = ysyx_22050133_MDU_S_IDLE;
                default:                   state_d = ysyx_22050133_MDU_S_IDLE;
            endcase
        end
    end

    // FSM: outputs.
    always_comb begin
        in_ready  = (state_q == ysyx_22050133_MDU_S_IDLE);
        busy      = (state_q != ysyx_22050133_MDU_S_IDLE);
        out_valid = (state_q == ysyx_22050133_MDU_S_DONE);
        result    = result_q;
        dbg_state = state_q;
    end

    // Datapath next state.
    always_comb begin
        op_d     = op_q;
        word_d   = word_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        case (state_q)
            ysyx_22050133_MDU_S_IDLE: begin
                if (accept) begin
                    op_d   = aluop;
                    // High-half multiplies have no W form.
                    word_d = word && !mdu_is_mul_hi(aluop);
                    a_d    = src1;
                    b_d    = src2;
                end
            end
            ysyx_22050133_MDU_S_PREP: begin
                b_d    = mag_b;
                neg_d  = a_neg ^ b_neg;
                rneg_d = a_neg;
                cnt_d  = word_q ? 6'(ysyx_22050133_MDU_W_ITERS - 1)
                                : 6'(ysyx_22050133_MDU_D_ITERS - 1);
                // Special divides preload the final {remainder, quotient}.
                if (div_zero) begin
                    acc_d  = {opa, {64{1'b1}}};
                    neg_d  = 1'b0;
                    rneg_d = 1'b0;
                end else if (div_ovf) begin
                    acc_d  = {64'd0, opa};
                    neg_d  = 1'b0;
                    rneg_d = 1'b0;
                end else if (is_div && word_q) begin
                    // Align a 32-bit dividend so its MSB is shifted out first.
                    acc_d = {64'd0, mag_a[31:0], 32'd0};
                end else begin
                    acc_d = {64'd0, mag_a};
                end
            end
            ysyx_22050133_MDU_S_MLOOP,
            ysyx_22050133_MDU_S_DLOOP: begin
                acc_d = iter_acc;
                cnt_d = cnt_q - 6'd1;
            end
            ysyx_22050133_MDU_S_FIX: begin
                if (!flush) result_d = fix_res;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= 5'd0;
            word_q   <= 1'b0;
            a_q      <= 64'd0;
            b_q      <= 64'd0;
            acc_q    <= 128'd0;
            cnt_q    <= 6'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 64'd0;
        end else begin
            op_q     <= op_d;
            word_q   <= word_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050133_mdu_seq.sv
module tb_ysyx_22050133_mdu_seq;

    import ysyx_22050133_mdu_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  aluop;
    logic        word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    ysyx_22050133_mdu_seq #(.XLEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .word      (word),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit (%0d compared)", n_cmp);
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic hi_op(input logic [4:0] op);
        return (op == ALUop_MULH) || (op == ALUop_MULHSU) || (op == ALUop_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALUop_DIV) || (op == ALUop_DIVU) || (op == ALUop_REM) || (op == ALUop_REMU);
    endfunction

    function automatic logic div_special(input logic [4:0] op, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
        logic sgn;
        logic [63:0] x, y, minv;
        sgn  = (op == ALUop_DIV) || (op == ALUop_REM);
        x    = w ? (sgn ? sx32(a[31:0]) : {32'd0, a[31:0]}) : a;
        y    = w ? (sgn ? sx32(b[31:0]) : {32'd0, b[31:0]}) : b;
        minv = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        return (y == 64'd0) || (sgn && x == minv && y == {64{1'b1}});
    endfunction

    function automatic logic [63:0] ref_result(input logic [4:0] op, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [63:0]  x, y, q, rm, r, res, minv;
        logic ww, sgn;
        ww  = w && !hi_op(op);
        sgn = (op == ALUop_DIV) || (op == ALUop_REM);
        res = 64'd0;
        if (op == ALUop_MUL) begin
            res = ww ? sx32(a[31:0] * b[31:0]) : a * b;
        end else if (op == ALUop_MULH) begin
            p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
            res = p[127:64];
        end else if (op == ALUop_MULHSU) begin
            p = {{64{a[63]}}, a} * {64'd0, b};
            res = p[127:64];
        end else if (op == ALUop_MULHU) begin
            p = {64'd0, a} * {64'd0, b};
            res = p[127:64];
        end else begin
            x    = ww ? (sgn ? sx32(a[31:0]) : {32'd0, a[31:0]}) : a;
            y    = ww ? (sgn ? sx32(b[31:0]) : {32'd0, b[31:0]}) : b;
            minv = ww ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
            if (y == 64'd0) begin
                q  = {64{1'b1}};
                rm = x;
            end else if (sgn && x == minv && y == {64{1'b1}}) begin
                q  = x;
                rm = 64'd0;
            end else if (sgn) begin
                q  = $signed(x) / $signed(y);
                rm = $signed(x) % $signed(y);
            end else begin
                q  = x / y;
                rm = x % y;
            end
            r   = ((op == ALUop_REM) || (op == ALUop_REMU)) ? rm : q;
            res = ww ? sx32(r[31:0]) : r;
        end
        return res;
    endfunction

    // Cycles from accept to the cycle where out_valid is first high.
    function automatic int ref_latency(input logic [4:0] op, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        logic ww;
        ww = w && !hi_op(op);
        if (is_div_op(op) && div_special(op, ww, a, b)) return 3;
        return (ww ? 32 : 64) + 3;
    endfunction

    // ---------------- scoreboard compare process ----------------
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                check("result", result, exp_q[0]);
                if (out_ready && !flush) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    // mode 0: normal, hold out_ready low for 'stall' cycles in DONE
    // mode 1: flush in cycle 'when' after accept
    // mode 2: flush together with out_ready in DONE
    // mode 3: reset pulse in cycle 'when' after accept
    task automatic run_op(input logic [4:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input int stall, input int mode, input int when);
        int lat, exp_lat, guard, seen;
        logic busy_ok;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        aluop    = op;
        word     = w;
        src1     = a;
        src2     = b;
        exp_q.push_back(ref_result(op, w, a, b));
        exp_lat = ref_latency(op, w, a, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        src1     = ~a;
        src2     = ~b;
        lat      = 1;
        busy_ok  = 1'b1;
        while (!out_valid && lat <= 200) begin
            if (!busy || in_ready) busy_ok = 1'b0;
            if (mode == 1 && lat == when) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                void'(exp_q.pop_back());
                check("flush_busy_held", {63'd0, busy_ok}, 64'd1);
                check("flush_in_ready", {63'd0, in_ready}, 64'd1);
                seen = 0;
                for (int i = 0; i < exp_lat + 4; i++) begin
                    if (out_valid) seen++;
                    @(posedge clk); #1;
                end
                check("flush_no_out_valid", 64'(seen), 64'd0);
                return;
            end
            if (mode == 3 && lat == when) begin
                rst = 1'b1;
                #1;
                check("rst_in_ready", {63'd0, in_ready}, 64'd1);
                check("rst_busy", {63'd0, busy}, 64'd0);
                check("rst_out_valid", {63'd0, out_valid}, 64'd0);
                check("rst_result", result, 64'd0);
                exp_q.delete();
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_while_running", {63'd0, busy_ok}, 64'd1);
        if (!out_valid) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        if (mode == 2) begin
            flush     = 1'b1;
            out_ready = 1'b1;
            @(posedge clk); #1;
            flush     = 1'b0;
            out_ready = 1'b0;
            void'(exp_q.pop_back());
            check("flush_done_out_valid", {63'd0, out_valid}, 64'd0);
            check("flush_done_in_ready", {63'd0, in_ready}, 64'd1);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_handshake_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_handshake_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    function automatic logic [63:0] rand_opnd();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0: v = {$urandom, $urandom};
            1: v = 64'($urandom_range(0, 20));
            2: v = 64'd0;
            3: v = {64{1'b1}};
            4: v = 64'h8000_0000_0000_0000;
            default: v = {$urandom, 1'b1, 31'($urandom)};
        endcase
        return v;
    endfunction

    // ---------------- main sequence ----------------
    logic [4:0] ops [8];

    initial begin
        ops[0] = ALUop_MUL;  ops[1] = ALUop_MULH; ops[2] = ALUop_MULHSU; ops[3] = ALUop_MULHU;
        ops[4] = ALUop_DIV;  ops[5] = ALUop_DIVU; ops[6] = ALUop_REM;    ops[7] = ALUop_REMU;
        rst = 1'b1; in_valid = 1'b0; aluop = 5'd0; word = 1'b0;
        src1 = 64'd0; src2 = 64'd0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_state", {61'd0, dbg_state}, {61'd0, ysyx_22050133_MDU_S_IDLE});
        rst = 1'b0;
        @(posedge clk); #1;

        // Pin the model to hand-computed values.
        check("pin_mul", ref_result(ALUop_MUL, 1'b0, 64'd7, -64'sd3), 64'hFFFF_FFFF_FFFF_FFEB);
        check("pin_mulhsu", ref_result(ALUop_MULHSU, 1'b0, {64{1'b1}}, 64'd2), {64{1'b1}});
        check("pin_div", ref_result(ALUop_DIV, 1'b0, -64'sd7, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("pin_divw", ref_result(ALUop_DIV, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF),
              64'hFFFF_FFFF_8000_0000);
        check("pin_lat_mul", 64'(ref_latency(ALUop_MUL, 1'b0, 64'd7, 64'd3)), 64'd67);
        check("pin_lat_divzero", 64'(ref_latency(ALUop_DIV, 1'b0, 64'd5, 64'd0)), 64'd3);

        // Directed operations.
        run_op(ALUop_MUL,    1'b0, 64'd7, -64'sd3, 0, 0, 0);
        run_op(ALUop_MULHU,  1'b0, {64{1'b1}}, {64{1'b1}}, 0, 0, 0);
        run_op(ALUop_MULH,   1'b0, {64{1'b1}}, {64{1'b1}}, 1, 0, 0);
        run_op(ALUop_MULHSU, 1'b0, {64{1'b1}}, 64'd2, 0, 0, 0);
        run_op(ALUop_DIV,    1'b0, -64'sd7, 64'd2, 0, 0, 0);
        run_op(ALUop_REM,    1'b0, -64'sd7, 64'd2, 0, 0, 0);
        run_op(ALUop_DIVU,   1'b0, 64'd100, 64'd7, 0, 0, 0);
        run_op(ALUop_REMU,   1'b0, 64'd100, 64'd7, 2, 0, 0);
        run_op(ALUop_DIV,    1'b0, 64'd5, 64'd0, 0, 0, 0);
        run_op(ALUop_REM,    1'b0, 64'd5, 64'd0, 0, 0, 0);
        run_op(ALUop_DIV,    1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 0, 0, 0);
        run_op(ALUop_REM,    1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 0, 0, 0);
        run_op(ALUop_MUL,    1'b1, 64'h7FFF_FFFF, 64'd2, 0, 0, 0);
        run_op(ALUop_DIV,    1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF, 0, 0, 0);
        run_op(ALUop_MULH,   1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd4, 0, 0, 0);
        run_op(ALUop_REMU,   1'b1, 64'hDEAD_0000_0000_0064, 64'h1234_0000_0000_0007, 0, 0, 0);

        // Control scenarios.
        run_op(ALUop_DIV,    1'b0, 64'd1000, 64'd3, 0, 1, 10);
        run_op(ALUop_DIVU,   1'b0, 64'd100, 64'd7, 0, 0, 0);
        run_op(ALUop_MULHU,  1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 5, 0, 0);
        run_op(ALUop_REMU,   1'b0, 64'd77, 64'd5, 0, 2, 0);
        run_op(ALUop_REM,    1'b0, -64'sd77, 64'd5, 0, 0, 0);
        run_op(ALUop_MUL,    1'b0, 64'h1234_5678, 64'h9ABC_DEF0, 0, 3, 20);
        run_op(ALUop_MUL,    1'b0, -64'sd9, 64'd9, 0, 0, 0);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            run_op(ops[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                   rand_opnd(), rand_opnd(), $urandom_range(0, 3), 0, 0);
        end

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22050133_mdu_seq.md
# ysyx_22050133_mdu_seq

Multi-cycle multiply/divide sequencer for the RV64IM pipeline. The EX stage hands it one M-extension operation: decoded ALUop, W-flag and two 64-bit operands. It runs a one-bit-per-cycle shift-add multiply or restoring divide. It holds the result until EX consumes it, and asserts `busy` so hazard logic can stall the front end.

## Interface
Parameters
- `XLEN`, 64: operand/result width. Only 64 is supported.

Ports
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  EX presents an M-extension op.
- `in_ready`  out  1  high only in IDLE.
- `aluop`  in  5  one of ALUop_MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- `word`  in  1  RV64 W variant (ctrl_ex[5]).
- `src1`, `src2`  in  64  rs1/rs2 operands.
- `flush`  in  1  kill in-flight op (branch/trap redirect).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  EX accepts result.
- `result`  out  64  final rd value, already W-sign-extended.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, PREP, MLOOP, DLOOP, FIX, DONE.
- IDLE: accept on `in_valid & in_ready & !flush`. Latch op, word and operands.
- PREP:
  - word=1: truncate operands to low 32 bits (sign- or zero-extended per op); N=32.
  - word=0: N=64.
  - Take magnitudes of signed operands: MULH/DIV/REM both signed, MULHSU src1 only. Record result sign.
  - Divide special cases skip the loop (go directly to FIX):
    - divisor zero: quotient = all ones, remainder = dividend.
    - signed overflow (min / -1): quotient = dividend, remainder = 0.
- MLOOP: 128-bit accumulator, one multiplier bit per cycle, N cycles.
- DLOOP: restoring divide, one quotient bit per cycle, N cycles.
- FIX:
  - Negate when required: product by result sign, quotient by sign xor, remainder by dividend sign.
  - Select low half (MUL) or high half (MULH*), quotient or remainder.
  - word=1: sign-extend bit 31.
  - Register into `result`.
- DONE: `out_valid`=1. `result` stable until `out_ready`, then IDLE next cycle.
- MULH*/MULHSU/MULHU with word=1 are never decoded; treat them as word=0.
- Iteration counter is 6 bits and counts down to 0.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=1, `busy`=0, `out_valid`=0, `result`=0.
  - All internal registers 0.
- Normal latency: accept edge k; `out_valid` rises in cycle k+N+3 (67 for 64-bit, 35 for W).
- Special-case divides: `out_valid` at k+3.
- `flush` in any state: IDLE next cycle; `out_valid` drops; result discarded; no accept in that cycle.
- `flush` and `out_ready` together in DONE: flush wins; result is dropped.
- No accept in the handshake cycle (`in_ready`=0 in DONE). Minimum issue spacing is N+4 cycles.
- `rst` mid-operation: immediate return to reset values.
- `in_valid` while busy: ignored. Hazard logic holds EX via `busy`.

## Structure
- Shared defines file holds:
  - ALUop codes (existing).
  - State encoding localparams: `ysyx_22050133_MDU_S_*`, 3 bits.
  - `ysyx_22050133_MDU_W_ITERS`=32 and `_D_ITERS`=64.
- One sub-module, `ysyx_22050133_mdu_iter`: combinational single-step datapath.
  - Shift-add step on 128-bit accumulator.
  - Restoring subtract-shift step on remainder/quotient.
  - Selected by an is_div input.
- Sequencer owns the FSM, counter, sign bookkeeping and output registers.

## Test plan
- MUL 7 × -3: `result`=0xFFFFFFFFFFFFFFEB; `out_valid` exactly 67 cycles after accept; `busy` high throughout.
- MULHU 0xFFFFFFFFFFFFFFFF²: 0xFFFFFFFFFFFFFFFE. MULH -1×-1: 0. MULHSU -1×2: 0xFFFFFFFFFFFFFFFF.
- DIV -7/2: -3 (0xFFFFFFFFFFFFFFFD). REM -7/2: -1. DIVU 100/7: 14. REMU 100/7: 2.
- Special cases, each at latency 3:
  - DIV 5/0: all ones. REM 5/0: 5.
  - DIV 0x8000000000000000 / -1: 0x8000000000000000. REM: 0.
- W ops:
  - MULW 0x7FFFFFFF×2: 0xFFFFFFFFFFFFFFFE, latency 35.
  - DIVW src1=0x0000000180000000, src2=0xFFFFFFFF: 0xFFFFFFFF80000000, latency 3.
- Control:
  - `flush` in cycle 10 of a DIV: `out_valid` never rises; `in_ready`=1 next cycle; next op correct.
  - `out_ready` low 5 cycles in DONE: `result` stable.
  - `rst` pulse mid-MLOOP: all outputs at reset values.
